// File: rtl/fib_detect_seq.sv
// Classifies an unsigned value as Fibonacci or not and reports its index.
// Define FIB_DETECT_SEQ_CACHE_EN to add a one-entry last-result cache.
module fib_detect_seq #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             isfib,
  output logic [IDXW-1:0]  index
);

  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] w_x_nx;
  logic [AW-1:0]    r_a;
  logic [AW-1:0]    r_b;
  logic [AW-1:0]    w_a_nx;
  logic [AW-1:0]    w_b_nx;
  logic [AW-1:0]    w_xe;
  logic [IDXW-1:0]  r_k;
  logic [IDXW-1:0]  w_k_nx;
  logic [IDXW-1:0]  r_index;
  logic [IDXW-1:0]  w_index_nx;
  logic             r_isfib;
  logic             w_isfib_nx;
  logic             w_hs;

`ifdef FIB_DETECT_SEQ_CACHE_EN
  logic             r_cv;
  logic [WIDTH-1:0] r_cval;
  logic             r_cfib;
  logic [IDXW-1:0]  r_cidx;
  logic             r_hit;
  logic             w_hit_nx;
`endif

  assign w_xe      = {2'b00, r_x};
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_hs      = out_valid & out_ready;
  assign isfib     = r_isfib;
  assign index     = r_index;

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_k_nx     = r_k;
    w_isfib_nx = r_isfib;
    w_index_nx = r_index;
`ifdef FIB_DETECT_SEQ_CACHE_EN
    w_hit_nx   = r_hit;
`endif
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_x_nx     = in;
          w_a_nx     = '0;
          w_b_nx     = AW'(1);
          w_k_nx     = '0;
          w_state_nx = SEARCH;
`ifdef FIB_DETECT_SEQ_CACHE_EN
          w_hit_nx   = r_cv && (in == r_cval);
`endif
        end
      end
      SEARCH: begin
`ifdef FIB_DETECT_SEQ_CACHE_EN
        if (r_hit) begin
          w_isfib_nx = r_cfib;
          w_index_nx = r_cidx;
          w_state_nx = DONE;
        end else
`endif
        if (r_a == w_xe) begin
          w_isfib_nx = 1'b1;
          w_index_nx = r_k;
          w_state_nx = DONE;
        end else if (r_a > w_xe) begin
          w_isfib_nx = 1'b0;
          w_index_nx = r_k;
          w_state_nx = DONE;
        end else begin
          w_a_nx = r_b;
          w_b_nx = r_a + r_b;
          w_k_nx = r_k + IDXW'(1);
        end
      end
      DONE: begin
        if (w_hs) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_isfib <= 1'b0;
      r_index <= '0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_k     <= w_k_nx;
      r_isfib <= w_isfib_nx;
      r_index <= w_index_nx;
    end
  end

`ifdef FIB_DETECT_SEQ_CACHE_EN
  // Cache captures whatever result was just handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cv   <= 1'b0;
      r_cval <= '0;
      r_cfib <= 1'b0;
      r_cidx <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= w_hit_nx;
      if (w_hs) begin
        r_cv   <= 1'b1;
        r_cval <= r_x;
        r_cfib <= r_isfib;
        r_cidx <= r_index;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fib_detect_seq.sv
// Scoreboard bench for fib_detect_seq at WIDTH=8.
// Honours FIB_DETECT_SEQ_CACHE_EN for expected cache-hit latency.
module tb_fib_detect_seq;

`ifdef FIB_DETECT_SEQ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct {
    int v;
    logic f;
    logic [5:0] idx;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       isfib;
  logic [5:0] index;

  int   nchk = 0;
  int   nerr = 0;
  int   nhits = 0;
  bit   c_valid = 1'b0;
  int   c_val = 0;
  exp_t sb[$];

  fib_detect_seq #(.WIDTH(8), .IDXW(6)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in(in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .isfib(isfib),
    .index(index)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    longint a, b, t;
    int k;
    a = 0;
    b = 1;
    k = 0;
    while (a < v) begin
      t = a + b;
      a = b;
      b = t;
      k++;
    end
    e.v   = v;
    e.f   = (a == v);
    e.idx = 6'(k);
    e.lat = (CACHE && c_valid && c_val == v) ? 1 : k + 1;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_async: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic run_req(input int v);
    exp_t e, got;
    int n, lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in = 8'(v);
    sb.push_back(model(v));
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    e = sb.pop_front();
    nchk++;
    if (out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL timeout in=%0d: no out_valid in %0d edges", v, lat);
      do_reset();
      return;
    end
    got.f = isfib;
    got.idx = index;
    if (got.f === 1'b1) nhits++;
    if (lat != e.lat) begin
      nerr++;
      $display("FAIL latency in=%0d: got %0d want %0d", v, lat, e.lat);
    end
    nchk++;
    if (got.f !== e.f) begin
      nerr++;
      $display("FAIL isfib in=%0d: got %b want %b", v, got.f, e.f);
    end
    nchk++;
    if (got.idx !== e.idx) begin
      nerr++;
      $display("FAIL index in=%0d: got %0d want %0d", v, got.idx, e.idx);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    c_valid = 1'b1;
    c_val = v;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        isfib !== 1'b0 || index !== 6'd0) begin
      nerr++;
      $display("FAIL reset_state: rdy=%b ov=%b f=%b idx=%0d want 1 0 0 0",
               in_ready, out_valid, isfib, index);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    int vals[5] = '{0, 1, 4, 233, 255};
    foreach (vals[i]) run_req(vals[i]);
  endtask

  task automatic test_sweep();
    nhits = 0;
    for (int v = 0; v < 256; v++) run_req(v);
    nchk++;
    if (nhits != 13) begin
      nerr++;
      $display("FAIL sweep_hits: got %0d want 13", nhits);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in = 8'd144;
    sb.push_back(model(144));
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    e = sb.pop_front();
    nchk++;
    if (out_valid !== 1'b1 || lat != e.lat) begin
      nerr++;
      $display("FAIL stall_latency: got %0d want %0d", lat, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      in = 8'd7;
      @(posedge clk);
      #1;
      nchk++;
      if (isfib !== 1'b1 || index !== 6'd12 ||
          in_ready !== 1'b0 || out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL stall_hold c=%0d: f=%b idx=%0d rdy=%b ov=%b",
                 c, isfib, index, in_ready, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    c_valid = 1'b1;
    c_val = 144;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stall_release: rdy=%b ov=%b want 1/0",
               in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stall_ignored: rdy=%b ov=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    in = 8'd200;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0) seen++;
    end
    nchk++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL abort_no_result: out_valid seen %0d want 0", seen);
    end
    run_req(21);
  endtask

  task automatic test_back_to_back();
    run_req(233);
    run_req(233);
    do_reset();
    run_req(233);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_sweep();
    test_stall();
    test_abort();
    test_back_to_back();
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
